// File: rtl/pll_lock_sequencer.sv
// PLL reset and lock supervisor running on the PLL reference clock.
// Pulses the PLL reset, waits for lock with a bounded timeout and retry budget,
// qualifies lock as stable before releasing the downstream system reset, and
// re-sequences on loss of lock or on a software relock request.
module pll_lock_sequencer #(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES         = 7,
  parameter int unsigned CNT_W               = 20
) (
  input  logic       i_refclk,
  input  logic       i_rst,
  input  logic       i_pll_locked_in,
  input  logic       i_force_relock,
  output logic       o_pll_rst,
  output logic       o_sys_rst,
  output logic       o_pll_ready,
  output logic       o_fault,
  output logic [2:0] o_retry_count,
  output logic [7:0] o_lol_count
);

  // Terminal counts, compared against a counter that restarts at zero on every state entry.
  localparam logic [CNT_W-1:0] RstLast     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] StableLast  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [2:0]       MaxRetry    = 3'(MAX_RETRIES);

  typedef enum logic [2:0] {
    StResetPll,
    StWaitLock,
    StStabilize,
    StRun,
    StFault
  } state_e;

  logic             r_sync1;
  logic             r_sync2;
  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_retry;
  logic [7:0]       r_lol;
  logic             r_pll_rst;
  logic             r_sys_rst;
  logic             r_ready;
  logic             r_fault;

  logic             w_locked_s;
  state_e           w_state_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic [2:0]       w_retry_next;
  logic [7:0]       w_lol_next;

  assign w_locked_s = r_sync2;

  // Two-flop synchronizer for the asynchronous PLL locked indication.
  always_ff @(posedge i_refclk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_pll_locked_in;
      r_sync2 <= r_sync1;
    end
  end

  // Next state and retry budget; a relock request overrides every lock/timeout event.
  always_comb begin
    w_state_next = r_state;
    w_retry_next = r_retry;
    if (i_force_relock) begin
      w_state_next = StResetPll;
      w_retry_next = '0;
    end else begin
      case (r_state)
        StResetPll: begin
          if (r_cnt == RstLast) begin
            w_state_next = StWaitLock;
          end
        end
        StWaitLock: begin
          if (w_locked_s) begin
            w_state_next = StStabilize;
          end else if (r_cnt == TimeoutLast) begin
            if (r_retry == MaxRetry) begin
              w_state_next = StFault;
            end else begin
              w_retry_next = r_retry + 3'd1;
              w_state_next = StResetPll;
            end
          end
        end
        StStabilize: begin
          // A single unlocked cycle throws away the stability accumulated so far.
          if (!w_locked_s) begin
            w_state_next = StWaitLock;
          end else if (r_cnt == StableLast) begin
            w_state_next = StRun;
            w_retry_next = '0;
          end
        end
        StRun: begin
          w_retry_next = '0;
          if (!w_locked_s) begin
            w_state_next = StResetPll;
          end
        end
        StFault: begin
          w_state_next = StFault;
        end
        default: begin
          w_state_next = StResetPll;
        end
      endcase
    end
  end

  // Loss-of-lock counter; a drop in RUN counts even when a relock request lands together.
  always_comb begin
    w_lol_next = r_lol;
    if ((r_state == StRun) && !w_locked_s && (r_lol != 8'hFF)) begin
      w_lol_next = r_lol + 8'd1;
    end
  end

  // Shared cycle counter: zero on entry to any state, including a relock restart.
  always_comb begin
    w_cnt_next = r_cnt;
    if (i_force_relock || (w_state_next != r_state)) begin
      w_cnt_next = '0;
    end else if (r_state inside {StResetPll, StWaitLock, StStabilize}) begin
      w_cnt_next = r_cnt + CNT_W'(1);
    end
  end

  // State, counters and registered outputs all update on the same edge.
  always_ff @(posedge i_refclk) begin
    if (i_rst) begin
      r_state   <= StResetPll;
      r_cnt     <= '0;
      r_retry   <= '0;
      r_lol     <= '0;
      r_pll_rst <= 1'b1;
      r_sys_rst <= 1'b1;
      r_ready   <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_retry   <= w_retry_next;
      r_lol     <= w_lol_next;
      r_pll_rst <= (w_state_next == StResetPll) || (w_state_next == StFault);
      r_sys_rst <= (w_state_next != StRun);
      r_ready   <= (w_state_next == StRun);
      r_fault   <= (w_state_next == StFault);
    end
  end

  assign o_pll_rst     = r_pll_rst;
  assign o_sys_rst     = r_sys_rst;
  assign o_pll_ready   = r_ready;
  assign o_fault       = r_fault;
  assign o_retry_count = r_retry;
  assign o_lol_count   = r_lol;

endmodule
